// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the Sobel 3x3 window: beat/row tracking, line-buffer rotation and strobe generation.
// Optional SOBEL_CTRL_STALL_CNT_EN adds a saturating 32-bit input stall counter (stall_cnt).
module sobel_window_ctrl #(
    parameter int PIXEL     = 3,
    parameter int DATAWIDTH = 8,
    parameter int COL_W     = 10,
    parameter int ROW_W     = 11
) (
    input  logic                       clk,
    input  logic                       ARESETN,
    input  logic                       cfg_start,
    input  logic [COL_W-1:0]           cfg_width_beats,
    input  logic [ROW_W-1:0]           cfg_height,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    input  logic [PIXEL*DATAWIDTH-1:0] s_tdata,
    output logic                       lb_wr_en,
    output logic [COL_W-1:0]           lb_addr,
    output logic [PIXEL*DATAWIDTH-1:0] lb_wr_data,
    output logic [1:0]                 lb_rot,
    input  logic                       i_busy,
    output logic                       o_strobe,
    output logic                       o_tlast,
    output logic                       frame_done,
    output logic                       cfg_err,
    output logic                       tlast_err
`ifdef SOBEL_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [COL_W-1:0] w_q, col;
    logic [ROW_W-1:0] h_q, row;
    logic             active, acc, last_col, eor, cfg_ok, start_ok;

    assign active   = (state == FILL) || (state == RUN);
    // NOTE: s_tready is combinational from i_busy so a busy filter stage stalls input in the same cycle.
    assign s_tready = active && !i_busy;
    assign acc      = s_tvalid && s_tready;
    assign last_col = (col == w_q - COL_W'(1));
    assign eor      = acc && (last_col || s_tlast);
    assign cfg_ok   = (cfg_width_beats != '0) && (cfg_height >= ROW_W'(3));
    assign start_ok = (state == IDLE) && cfg_start && cfg_ok;

    assign lb_wr_en   = acc;
    assign lb_addr    = col;
    assign lb_wr_data = s_tdata;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = FILL;
            FILL:    if (eor && (row == ROW_W'(1))) state_nxt = RUN;
            RUN:     if (eor && (row == h_q - ROW_W'(1))) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            col        <= '0;
            row        <= '0;
            lb_rot     <= '0;
            o_strobe   <= 1'b0;
            o_tlast    <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            tlast_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_strobe   <= (state == RUN) && acc;
            o_tlast    <= (state == RUN) && eor;
            frame_done <= (state == DONE);
            if ((state == IDLE) && cfg_start && !cfg_ok) cfg_err <= 1'b1;
            if (start_ok) begin
                w_q <= cfg_width_beats;
                h_q <= cfg_height;
                col <= '0;
                row <= '0;
            end else if (acc) begin
                if (eor) begin
                    col    <= '0;
                    row    <= row + ROW_W'(1);
                    lb_rot <= (lb_rot == 2'd2) ? 2'd0 : lb_rot + 2'd1;
                end else begin
                    col <= col + COL_W'(1);
                end
                // A misplaced tlast, either early or missing, is flagged but the row still ends.
                if (s_tlast != last_col) tlast_err <= 1'b1;
            end
        end
    end

`ifdef SOBEL_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge ARESETN) begin
        if (!ARESETN) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (active && s_tvalid && !s_tready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: directed scenarios plus randomized frames against a row/column model.
module tb_sobel_window_ctrl;
    localparam int PIXEL = 3, DATAWIDTH = 8, COL_W = 10, ROW_W = 11;

    logic                       clk = 1'b0;
    logic                       ARESETN = 1'b0;
    logic                       cfg_start = 1'b0;
    logic [COL_W-1:0]           cfg_width_beats = '0;
    logic [ROW_W-1:0]           cfg_height = '0;
    logic                       s_tvalid = 1'b0;
    logic                       s_tready;
    logic                       s_tlast = 1'b0;
    logic [PIXEL*DATAWIDTH-1:0] s_tdata = '0;
    logic                       lb_wr_en;
    logic [COL_W-1:0]           lb_addr;
    logic [PIXEL*DATAWIDTH-1:0] lb_wr_data;
    logic [1:0]                 lb_rot;
    logic                       i_busy = 1'b0;
    logic                       o_strobe, o_tlast, frame_done, cfg_err, tlast_err;
`ifdef SOBEL_CTRL_STALL_CNT_EN
    logic [31:0]                stall_cnt;
`endif

    sobel_window_ctrl #(.PIXEL(PIXEL), .DATAWIDTH(DATAWIDTH), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk(clk), .ARESETN(ARESETN), .cfg_start(cfg_start), .cfg_width_beats(cfg_width_beats),
        .cfg_height(cfg_height), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tdata(s_tdata), .lb_wr_en(lb_wr_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
        .lb_rot(lb_rot), .i_busy(i_busy), .o_strobe(o_strobe), .o_tlast(o_tlast),
        .frame_done(frame_done), .cfg_err(cfg_err), .tlast_err(tlast_err)
`ifdef SOBEL_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame position as plain integers plus expected registered outputs.
    int          m_w, m_h, m_col, m_row, m_rot;
    bit          m_active, m_done_wait, m_cfg_err, m_tlast_err;
    bit          e_strobe, e_tlast, e_fd;
    int unsigned m_stall;
    int          n_strobe, n_tlast, n_wr, n_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_h = 0; m_col = 0; m_row = 0; m_rot = 0;
        m_active = 0; m_done_wait = 0; m_cfg_err = 0; m_tlast_err = 0;
        e_strobe = 0; e_tlast = 0; e_fd = 0; m_stall = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit exp_ready, exp_acc, eor, idle, wrap_col;
        @(negedge clk);
        exp_ready = m_active && !i_busy;
        exp_acc   = exp_ready && s_tvalid;
        check("s_tready", 32'(s_tready), 32'(exp_ready));
        check("lb_wr_en", 32'(lb_wr_en), 32'(exp_acc));
        check("lb_addr", 32'(lb_addr), 32'(m_col));
        check("lb_wr_data", 32'(lb_wr_data), 32'(s_tdata));
        check("lb_rot", 32'(lb_rot), 32'(m_rot));
        check("o_strobe", 32'(o_strobe), 32'(e_strobe));
        check("o_tlast", 32'(o_tlast), 32'(e_tlast));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
        check("tlast_err", 32'(tlast_err), 32'(m_tlast_err));
`ifdef SOBEL_CTRL_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        n_strobe += int'(o_strobe);
        n_tlast  += int'(o_tlast);
        n_wr     += int'(lb_wr_en);
        n_fd     += int'(frame_done);

        idle        = !m_active && !m_done_wait;
        e_fd        = m_done_wait;
        m_done_wait = 0;
        e_strobe    = exp_acc && (m_row >= 2);
        e_tlast     = 0;
        if (m_active && s_tvalid && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (exp_acc) begin
            wrap_col = (m_col == m_w - 1);
            eor      = wrap_col || s_tlast;
            if (s_tlast != wrap_col) m_tlast_err = 1;
            if (eor) begin
                e_tlast = e_strobe;
                if (m_row == m_h - 1) begin
                    m_active    = 0;
                    m_done_wait = 1;
                end
                m_col = 0;
                m_row++;
                m_rot = (m_rot + 1) % 3;
            end else begin
                m_col++;
            end
        end
        if (cfg_start && idle) begin
            if (cfg_width_beats == 0 || cfg_height < 3) begin
                m_cfg_err = 1;
            end else begin
                m_w = int'(cfg_width_beats); m_h = int'(cfg_height);
                m_col = 0; m_row = 0; m_active = 1; m_stall = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input int w, input int h);
        cfg_start = 1; cfg_width_beats = COL_W'(w); cfg_height = ROW_W'(h);
        tick();
        cfg_start = 0;
    endtask

    // bad_row/bad_col: beat whose tlast is inverted (-1 for none). busy_* forces a busy burst with valid held.
    task automatic run_frame(input int w, input int h, input int valid_pct, input int busy_pct,
                             input int bad_row, input int bad_col, input int busy_row,
                             input int busy_col, input int busy_len, input bit start_mid);
        int cycles, busy_left, fd_before, exp_wr, exp_strobe, short_by;
        bit busy_used, mid_sent;
        cycles = 0; busy_left = 0; busy_used = 0; mid_sent = 0;
        n_strobe = 0; n_tlast = 0; n_wr = 0;
        fd_before = n_fd;
        start_pulse(w, h);
        while (n_fd == fd_before && cycles < 5000) begin
            s_tvalid = ($urandom_range(99) < valid_pct);
            if (m_active && !busy_used && m_row == busy_row && m_col == busy_col) begin
                busy_left = busy_len; busy_used = 1;
            end
            if (busy_left > 0) begin
                i_busy = 1; s_tvalid = 1; busy_left--;
            end else begin
                i_busy = ($urandom_range(99) < busy_pct);
            end
            s_tlast = (m_col == w - 1);
            if (m_row == bad_row && m_col == bad_col) s_tlast = !s_tlast;
            s_tdata = PIXEL*DATAWIDTH'($urandom);
            if (start_mid && !mid_sent && m_active && m_row == 2) begin
                cfg_start = 1; cfg_width_beats = COL_W'($urandom_range(1, 9));
                cfg_height = ROW_W'($urandom_range(3, 9)); mid_sent = 1;
            end
            tick();
            cfg_start = 0;
            cycles++;
        end
        s_tvalid = 0; i_busy = 0; s_tlast = 0;
        check("frame_timeout", 32'(cycles < 5000), 32'd1);
        check("frame_done_count", 32'(n_fd - fd_before), 32'd1);
        short_by   = (bad_col >= 0 && bad_col < w - 1) ? (w - 1 - bad_col) : 0;
        exp_wr     = w * h - short_by;
        exp_strobe = (h - 2) * w - ((bad_row >= 2) ? short_by : 0);
        check("wr_total", 32'(n_wr), 32'(exp_wr));
        check("strobe_total", 32'(n_strobe), 32'(exp_strobe));
        check("tlast_total", 32'(n_tlast), 32'(h - 2));
    endtask

    initial begin
        model_reset();
        n_fd = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_lb_rot", 32'(lb_rot), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        ARESETN = 1;
        repeat (2) tick();

        // Basic 4x4 frame, continuous valid, correct tlast.
        run_frame(4, 4, 100, 0, -1, -1, -1, -1, 0, 0);
        check("basic_lb_rot_end", 32'(lb_rot), 32'd1);
        check("basic_tlast_err", 32'(tlast_err), 32'd0);
        repeat (2) tick();

        // Backpressure: 4x3, busy for 3 cycles in row 2.
        run_frame(4, 3, 100, 0, -1, -1, 2, 1, 3, 0);
        repeat (2) tick();

        // Early tlast on col 2 of row 0.
        run_frame(4, 4, 100, 0, 0, 2, -1, -1, 0, 0);
        check("early_tlast_err", 32'(tlast_err), 32'd1);
        repeat (2) tick();

        // Bad config, then a valid small frame; cfg_err stays set.
        start_pulse(4, 2);
        check("badcfg_cfg_err", 32'(cfg_err), 32'd1);
        repeat (2) tick();
        run_frame(2, 3, 100, 0, -1, -1, -1, -1, 0, 0);
        check("badcfg_sticky", 32'(cfg_err), 32'd1);
        start_pulse(0, 5);
        repeat (2) tick();

        // cfg_start during RUN ignored; 5 busy cycles with valid held.
        run_frame(3, 4, 100, 0, -1, -1, 2, 0, 5, 1);
`ifdef SOBEL_CTRL_STALL_CNT_EN
        check("stall_cnt_5", stall_cnt, 32'd5);
`endif
        repeat (2) tick();

        // Reset mid-RUN clears everything immediately, including sticky errors.
        start_pulse(3, 5);
        s_tvalid = 1;
        while (m_active && m_row < 3) begin
            s_tlast = (m_col == 2);
            tick();
        end
        ARESETN = 0;
        #1;
        check("mid_rst_s_tready", 32'(s_tready), 32'd0);
        check("mid_rst_lb_wr_en", 32'(lb_wr_en), 32'd0);
        check("mid_rst_lb_addr", 32'(lb_addr), 32'd0);
        check("mid_rst_lb_rot", 32'(lb_rot), 32'd0);
        check("mid_rst_o_strobe", 32'(o_strobe), 32'd0);
        check("mid_rst_o_tlast", 32'(o_tlast), 32'd0);
        check("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        check("mid_rst_tlast_err", 32'(tlast_err), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        ARESETN = 1;
        model_reset();
        repeat (4) tick();
        check("post_rst_no_done", 32'(n_fd), 32'd5);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            int w, h, br, bc;
            w  = $urandom_range(1, 6);
            h  = $urandom_range(3, 6);
            br = -1; bc = -1;
            if ($urandom_range(99) < 30) begin
                br = $urandom_range(0, h - 1);
                bc = $urandom_range(0, w - 1);
            end
            run_frame(w, h, $urandom_range(60, 100), $urandom_range(0, 30), br, bc,
                      $urandom_range(0, h - 1), $urandom_range(0, w - 1), $urandom_range(1, 4),
                      $urandom_range(0, 1) == 1);
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
- Sequencer for the Sobel 3x3 window datapath.
- Accepts a PIXEL-wide input pixel stream, tracks the column (beat) and row position in the frame, and rotates the three line buffers.
- Drives the strobe and tlast into the filter adder stage, and holds off input while that stage reports busy.
- Sits between the AXI-Stream input slave and the line buffers plus filter_add pipeline.

Parameters:
- PIXEL, 3, pixels per stream beat.
- DATAWIDTH, 8, bits per pixel; used only for the pass-through data width.
- COL_W, 10, width of the column (beat) counter and of cfg_width_beats.
- ROW_W, 11, width of the row counter and of cfg_height.

Ports:
- clk  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse; starts a frame, honoured in IDLE only.
- cfg_width_beats  in  COL_W  beats per row; sampled on cfg_start.
- cfg_height  in  ROW_W  rows per frame; sampled on cfg_start.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid && s_tready.
- s_tlast  in  1  end-of-row marker on the input.
- lb_wr_en  out  1  write the current beat into the newest line buffer.
- lb_addr  out  COL_W  line-buffer beat address (equals the column count).
- lb_rot  out  2  index (0..2) of the line buffer holding the newest row.
- i_busy  in  1  busy from the filter stage.
- o_strobe  out  1  window valid into the filter stage.
- o_tlast  out  1  last window of an output row.
- frame_done  out  1  one-cycle pulse after the final beat of the frame.
- cfg_err  out  1  sticky: illegal configuration seen on cfg_start.
- tlast_err  out  1  sticky: s_tlast position did not match cfg_width_beats.

Behaviour:
- Reset is asynchronous and active-low; all outputs and state are cleared while ARESETN is low.
- Reset values: s_tready=0, lb_wr_en=0, lb_addr=0, lb_rot=0, o_strobe=0, o_tlast=0, frame_done=0, cfg_err=0, tlast_err=0; state=IDLE.
- Reset mid-frame abandons the frame with no frame_done.
- States: IDLE, FILL, RUN, DONE.
- IDLE:
  - s_tready=0.
  - On cfg_start: if cfg_width_beats==0 or cfg_height<3, set cfg_err and stay in IDLE.
  - Otherwise latch W=cfg_width_beats and H=cfg_height, clear col/row, go to FILL.
  - cfg_start in any other state is ignored.
- s_tready = (state==FILL || state==RUN) && !i_busy. It is combinational from i_busy.
- Accept event (acc = s_tvalid && s_tready) in both FILL and RUN:
  - lb_wr_en=acc, combinational; lb_addr=col.
  - col increments on acc.
  - End of row (eor) occurs when col==W-1, or when s_tlast is accepted.
  - On eor: col←0, row←row+1, lb_rot←(lb_rot==2)?0:lb_rot+1.
- FILL:
  - Covers rows 0 and 1; no o_strobe is generated.
  - When the eor of row 1 occurs, go to RUN.
- RUN:
  - Each acc produces o_strobe=1 one cycle later (registered); otherwise o_strobe=0.
  - o_tlast is registered alongside and is 1 only for the strobe generated by an eor beat.
- On eor of row H-1: go to DONE, then pulse frame_done for one cycle, then return to IDLE.
- Strobe count per frame: exactly (H-2)*W when tlast is well placed.
- tlast checking:
  - s_tlast=1 accepted with col!=W-1 sets tlast_err; the row ends early.
  - col==W-1 accepted with s_tlast=0 also sets tlast_err; the row still ends.
- i_busy high: s_tready drops in the same cycle, no acc occurs, counters hold, and o_strobe is 0 in the next cycle.
- Simultaneous eor and i_busy rising: the eor beat was accepted, so the counters advance and the next beat stalls.
- Counter wrap: col never exceeds W-1; lb_rot wraps 2→0.
- cfg_err and tlast_err clear only on reset.

Optional Feature:
- Macro: SOBEL_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits.
  - Counts cycles with s_tvalid && !s_tready while in FILL or RUN.
  - Clears on accepted cfg_start; saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset state: hold ARESETN low mid-RUN → all outputs 0 immediately; after release, state is IDLE and s_tready=0.
- Basic frame: cfg 4 beats x 4 rows, continuous valid, correct tlast → 16 lb_wr_en pulses; 8 o_strobe pulses, each 1 cycle after its acc; o_tlast on strobes 4 and 8; lb_rot sequence 0,1,2,0,1; one frame_done; no errors.
- Backpressure: 4x3 frame, i_busy high for 3 cycles during row 2 → s_tready low in those cycles, col frozen, no o_strobe in the following cycles, total strobes 4.
- Early tlast: W=4, s_tlast on col 2 of row 0 → tlast_err=1, row 1 starts at col 0, frame completes one beat short.
- Bad config: cfg_start with H=2 → cfg_err=1, state stays IDLE, s_tready=0; a later valid cfg_start (W=2, H=3) runs normally and cfg_err stays 1.
- Ignored start and stall count: cfg_start pulsed during RUN → no effect on counters. With SOBEL_CTRL_STALL_CNT_EN and 5 busy cycles with valid high → stall_cnt=5.
